// File: rtl/partition_stats_pkg.sv
// Shared definitions for the median-search partition stage.
// Holds the sample class encodings driven on cls_sel and the initial
// values the partition extremes start from, and return to, on every frame.
package partition_stats_pkg;

    // Sample class relative to the frame pivot (cls_sel encoding).
    typedef enum logic [1:0] {
        CLS_LOWER  = 2'b00,
        CLS_EQUAL  = 2'b01,
        CLS_LARGER = 2'b10
    } cls_e;

    // An empty partition reports min above max, so a consumer can tell
    // it is empty without reading the count.
    localparam logic [7:0] MIN_INIT = 8'hFF;
    localparam logic [7:0] MAX_INIT = 8'h00;

endpackage

// File: rtl/partition_classify.sv
// Combinational sample classifier.
// Ports:
//   data  - sample value
//   pivot - pivot value the sample is compared against
//   sel   - class of the sample: lower / equal / larger
module partition_classify
    import partition_stats_pkg::*;
(
    input  logic [7:0] data,
    input  logic [7:0] pivot,
    output cls_e       sel
);

    always_comb begin
        sel = CLS_EQUAL;
        if (data < pivot) begin
            sel = CLS_LOWER;
        end else if (data > pivot) begin
            sel = CLS_LARGER;
        end
    end

endmodule

// File: rtl/partition_stats.sv
// Partition statistics for one frame of 8-bit samples.
// Each sample of a frame is classified against the pivot captured with the
// frame's first sample. Per-class counts and lower/larger extremes are
// accumulated, and each counted sample is echoed on the cls_* port so the
// buffer writers can store it. After the last sample the results are held
// on the out_* ports until the next-pivot stage accepts them.
// Ports:
//   aclk, aresetn                        - clock, async active-low reset
//   in_data/in_valid/in_last/in_ready    - sample stream
//   in_pivot, in_median_pos              - frame parameters, taken on the first sample
//   cls_valid/cls_sel/cls_data           - registered per-sample routing
//   lower/equal/larger_size              - partition counts
//   max/min_lower, max/min_larger        - partition extremes
//   out_pivot, out_median_pos, out_ovf   - frame results
//   out_valid/out_ready                  - result handshake
module partition_stats
    import partition_stats_pkg::*;
#(
    parameter int BUFF_SIZE     = 32,
    parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    input  logic [7:0]               in_pivot,
    input  logic [BUFF_SIZE_BIT-1:0] in_median_pos,
    output logic                     cls_valid,
    output logic [1:0]               cls_sel,
    output logic [7:0]               cls_data,
    output logic [BUFF_SIZE_BIT-1:0] lower_size,
    output logic [BUFF_SIZE_BIT-1:0] equal_size,
    output logic [BUFF_SIZE_BIT-1:0] larger_size,
    output logic [7:0]               max_lower,
    output logic [7:0]               min_lower,
    output logic [7:0]               max_larger,
    output logic [7:0]               min_larger,
    output logic [7:0]               out_pivot,
    output logic [BUFF_SIZE_BIT-1:0] out_median_pos,
    output logic                     out_ovf,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    logic [1:0]               state;
    logic                     xfer;
    logic                     full;
    logic [7:0]               pivot_cmp;
    logic [BUFF_SIZE_BIT-1:0] total;
    cls_e                     sel;

    assign in_ready = (state != ST_OUT);
    assign xfer     = in_valid && in_ready;

    // The first sample of a frame is compared against the live pivot, since
    // out_pivot only picks it up on that same edge; later samples use the
    // captured copy so a changing in_pivot cannot disturb the frame.
    assign pivot_cmp = (state == ST_IDLE) ? in_pivot : out_pivot;

    // Counts saturate as a group, so their sum never exceeds BUFF_SIZE and
    // fits in BUFF_SIZE_BIT without wrapping.
    assign total = lower_size + equal_size + larger_size;
    assign full  = (total >= BUFF_SIZE_BIT'(BUFF_SIZE));

    partition_classify u_classify (
        .data  (in_data),
        .pivot (pivot_cmp),
        .sel   (sel)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= ST_IDLE;
            lower_size     <= '0;
            equal_size     <= '0;
            larger_size    <= '0;
            min_lower      <= MIN_INIT;
            max_lower      <= MAX_INIT;
            min_larger     <= MIN_INIT;
            max_larger     <= MAX_INIT;
            out_pivot      <= '0;
            out_median_pos <= '0;
            out_ovf        <= 1'b0;
            out_valid      <= 1'b0;
            cls_valid      <= 1'b0;
            cls_sel        <= '0;
            cls_data       <= '0;
        end else begin
            cls_valid <= 1'b0;
            cls_sel   <= '0;
            cls_data  <= '0;

            if (xfer) begin
                if (state == ST_IDLE) begin
                    out_pivot      <= in_pivot;
                    out_median_pos <= in_median_pos;
                end

                if (full) begin
                    out_ovf <= 1'b1;
                end else begin
                    cls_valid <= 1'b1;
                    cls_sel   <= sel;
                    cls_data  <= in_data;
                    case (sel)
                        CLS_LOWER: begin
                            lower_size <= lower_size + 1'b1;
                            if (in_data < min_lower) min_lower <= in_data;
                            if (in_data > max_lower) max_lower <= in_data;
                        end
                        CLS_EQUAL: begin
                            equal_size <= equal_size + 1'b1;
                        end
                        default: begin
                            larger_size <= larger_size + 1'b1;
                            if (in_data < min_larger) min_larger <= in_data;
                            if (in_data > max_larger) max_larger <= in_data;
                        end
                    endcase
                end

                if (in_last) begin
                    state     <= ST_OUT;
                    out_valid <= 1'b1;
                end else begin
                    state <= ST_ACCUM;
                end
            end else if ((state == ST_OUT) && out_ready) begin
                // Results are cleared on the accepting edge so the next
                // frame starts from empty partitions.
                state       <= ST_IDLE;
                out_valid   <= 1'b0;
                lower_size  <= '0;
                equal_size  <= '0;
                larger_size <= '0;
                min_lower   <= MIN_INIT;
                max_lower   <= MAX_INIT;
                min_larger  <= MIN_INIT;
                max_larger  <= MAX_INIT;
                out_ovf     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_partition_stats.sv
module tb_partition_stats;

    localparam int BS  = 32;
    localparam int BSB = $clog2(BS) + 1;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic [7:0]     in_data;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [7:0]     in_pivot;
    logic [BSB-1:0] in_median_pos;
    logic           cls_valid;
    logic [1:0]     cls_sel;
    logic [7:0]     cls_data;
    logic [BSB-1:0] lower_size, equal_size, larger_size;
    logic [7:0]     max_lower, min_lower, max_larger, min_larger;
    logic [7:0]     out_pivot;
    logic [BSB-1:0] out_median_pos;
    logic           out_ovf;
    logic           out_valid;
    logic           out_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 aclk = ~aclk;

    partition_stats #(.BUFF_SIZE(BS)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .in_pivot       (in_pivot),
        .in_median_pos  (in_median_pos),
        .cls_valid      (cls_valid),
        .cls_sel        (cls_sel),
        .cls_data       (cls_data),
        .lower_size     (lower_size),
        .equal_size     (equal_size),
        .larger_size    (larger_size),
        .max_lower      (max_lower),
        .min_lower      (min_lower),
        .max_larger     (max_larger),
        .min_larger     (min_larger),
        .out_pivot      (out_pivot),
        .out_median_pos (out_median_pos),
        .out_ovf        (out_ovf),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_sizes(input string tag, input int lo, input int eq, input int la);
        check({tag, ".lower_size"},  32'(lower_size),  32'(lo));
        check({tag, ".equal_size"},  32'(equal_size),  32'(eq));
        check({tag, ".larger_size"}, 32'(larger_size), 32'(la));
    endtask

    task automatic check_ext(input string tag, input int mnl, input int mxl, input int mng, input int mxg);
        check({tag, ".min_lower"},  32'(min_lower),  32'(mnl));
        check({tag, ".max_lower"},  32'(max_lower),  32'(mxl));
        check({tag, ".min_larger"}, 32'(min_larger), 32'(mng));
        check({tag, ".max_larger"}, 32'(max_larger), 32'(mxg));
    endtask

    // Accept the held result and confirm the clear on the accepting edge.
    task automatic accept(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".out_valid_clr"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready_clr"},  32'(in_ready),  32'd1);
        check_sizes({tag, ".clr"}, 0, 0, 0);
        check_ext({tag, ".clr"}, 8'hFF, 8'h00, 8'hFF, 8'h00);
        check({tag, ".ovf_clr"}, 32'(out_ovf), 32'd0);
    endtask

    initial begin
        aresetn       = 1'b0;
        in_data       = 8'd0;
        in_valid      = 1'b0;
        in_last       = 1'b0;
        in_pivot      = 8'd0;
        in_median_pos = '0;
        out_ready     = 1'b0;

        // ---- reset values
        #23;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.cls_valid", 32'(cls_valid), 32'd0);
        check("rst.out_pivot", 32'(out_pivot), 32'd0);
        check_sizes("rst", 0, 0, 0);
        check_ext("rst", 8'hFF, 8'h00, 8'hFF, 8'h00);
        aresetn = 1'b1;
        #4;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        tick();

        // ---- in_last without in_valid is ignored
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
        check("lastnv.out_valid", 32'(out_valid), 32'd0);
        check("lastnv.in_ready",  32'(in_ready),  32'd1);

        // ---- basic frame: pivot 100, 90,100,110,50,200
        in_pivot      = 8'd100;
        in_median_pos = BSB'(16);
        send(8'd90, 1'b0);
        check("basic.cls_valid0", 32'(cls_valid), 32'd1);
        check("basic.cls_sel0",   32'(cls_sel),   32'd0);
        check("basic.cls_data0",  32'(cls_data),  32'd90);
        send(8'd100, 1'b0);
        check("basic.cls_sel1", 32'(cls_sel), 32'd1);
        send(8'd110, 1'b0);
        check("basic.cls_sel2", 32'(cls_sel), 32'd2);
        check("basic.out_valid_mid", 32'(out_valid), 32'd0);
        send(8'd50, 1'b0);
        send(8'd200, 1'b1);
        check("basic.out_valid", 32'(out_valid), 32'd1);
        check("basic.in_ready",  32'(in_ready),  32'd0);
        check_sizes("basic", 2, 1, 2);
        check_ext("basic", 50, 90, 110, 200);
        check("basic.out_pivot",  32'(out_pivot),      32'd100);
        check("basic.median_pos", 32'(out_median_pos), 32'd16);
        check("basic.ovf",        32'(out_ovf),        32'd0);
        tick();
        check("basic.cls_valid_idle", 32'(cls_valid), 32'd0);
        check("basic.cls_data_idle",  32'(cls_data),  32'd0);
        accept("basic");

        // ---- pivot changes mid-frame: 100 -> 10
        in_pivot = 8'd100;
        send(8'd100, 1'b0);
        in_pivot = 8'd10;
        send(8'd50, 1'b0);
        check("pivchg.cls_sel", 32'(cls_sel), 32'd0);
        in_last = 1'b1;   // in_last with no valid mid-frame is ignored
        tick();
        in_last = 1'b0;
        check("pivchg.no_end", 32'(out_valid), 32'd0);
        send(8'd150, 1'b1);
        check_sizes("pivchg", 1, 1, 1);
        check_ext("pivchg", 50, 50, 150, 150);
        check("pivchg.out_pivot", 32'(out_pivot), 32'd100);
        accept("pivchg");

        // ---- 32 equal samples
        in_pivot = 8'd7;
        for (int i = 1; i <= 32; i++) send(8'd7, (i == 32));
        check("eq32.out_valid", 32'(out_valid), 32'd1);
        check_sizes("eq32", 0, 32, 0);
        check_ext("eq32", 8'hFF, 8'h00, 8'hFF, 8'h00);
        check("eq32.ovf", 32'(out_ovf), 32'd0);
        accept("eq32");

        // ---- overflow: 34 samples of value 1..34 below pivot 100
        in_pivot = 8'd100;
        for (int i = 1; i <= 34; i++) begin
            send(8'(i), (i == 34));
            if (i == 32) begin
                check("ovf.cls_valid32", 32'(cls_valid), 32'd1);
                check("ovf.ovf32",       32'(out_ovf),   32'd0);
            end
            if (i >= 33) check($sformatf("ovf.cls_valid%0d", i), 32'(cls_valid), 32'd0);
        end
        check("ovf.out_valid", 32'(out_valid), 32'd1);
        check_sizes("ovf", 32, 0, 0);
        check_ext("ovf", 1, 32, 8'hFF, 8'h00);
        check("ovf.ovf", 32'(out_ovf), 32'd1);

        // ---- back-pressure in OUT: 5 cycles, in_valid held high
        in_data  = 8'd200;
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall.in_ready",  32'(in_ready),   32'd0);
            check("stall.out_valid", 32'(out_valid),  32'd1);
            check("stall.lower",     32'(lower_size), 32'd32);
            check("stall.larger",    32'(larger_size), 32'd0);
            check("stall.cls_valid", 32'(cls_valid),  32'd0);
            check("stall.ovf",       32'(out_ovf),    32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        accept("stall");

        // ---- single-sample frame
        in_pivot      = 8'd10;
        in_median_pos = BSB'(1);
        send(8'd200, 1'b1);
        check("one.out_valid", 32'(out_valid), 32'd1);
        check_sizes("one", 0, 0, 1);
        check_ext("one", 8'hFF, 8'h00, 200, 200);
        check("one.median_pos", 32'(out_median_pos), 32'd1);
        accept("one");

        // ---- async reset mid-frame
        in_pivot = 8'd50;
        send(8'd10, 1'b0);
        send(8'd60, 1'b0);
        send(8'd50, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        check("arst.cls_valid", 32'(cls_valid), 32'd0);
        check("arst.out_pivot", 32'(out_pivot), 32'd0);
        check_sizes("arst", 0, 0, 0);
        check_ext("arst", 8'hFF, 8'h00, 8'hFF, 8'h00);
        #3;
        aresetn = 1'b1;
        tick();
        in_pivot      = 8'd25;
        in_median_pos = BSB'(2);
        send(8'd20, 1'b0);
        send(8'd30, 1'b1);
        check("post.out_valid", 32'(out_valid), 32'd1);
        check_sizes("post", 1, 0, 1);
        check_ext("post", 20, 20, 30, 30);
        check("post.out_pivot", 32'(out_pivot), 32'd25);
        accept("post");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/partition_stats.md
PARTITION_STATS -- requirements
Module: partition_stats

Interface
REQ-001 SHALL have parameter BUFF_SIZE, default 32, max samples per frame.
REQ-002 SHALL have parameter BUFF_SIZE_BIT, default $clog2(BUFF_SIZE)+1, width of size/position fields.
REQ-003 SHALL have port aclk  in  1  single clock, all logic rising-edge.
REQ-004 SHALL have port aresetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_data in 8, in_valid in 1, in_last in 1, in_ready out 1: sample stream; in_last marks the frame's final sample.
REQ-006 SHALL have ports in_pivot in 8, in_median_pos in BUFF_SIZE_BIT: frame parameters.
REQ-007 SHALL have ports cls_valid out 1, cls_sel out 2 (00 lower, 01 equal, 10 larger), cls_data out 8: per-sample routing to the buffer writers.
REQ-008 SHALL have ports lower_size, equal_size, larger_size out BUFF_SIZE_BIT each: partition counts.
REQ-009 SHALL have ports max_lower, min_lower, max_larger, min_larger out 8 each: partition extremes.
REQ-010 SHALL have ports out_pivot out 8, out_median_pos out BUFF_SIZE_BIT, out_ovf out 1, out_valid out 1, out_ready in 1: result handshake to the next-pivot stage.

Function
REQ-011 SHALL implement FSM IDLE, ACCUM, OUT; transfer occurs when in_valid&&in_ready.
REQ-012 in_ready SHALL be 1 in IDLE and ACCUM, 0 in OUT.
REQ-013 IDLE: first transfer SHALL register in_pivot/in_median_pos into out_pivot/out_median_pos and classify that sample; go ACCUM, or OUT if in_last.
REQ-014 ACCUM: each transfer SHALL be classified against the registered pivot, never the live in_pivot; transfer with in_last -> OUT.
REQ-015 Classification: data<pivot lower, ==pivot equal, >pivot larger; the matching count increments by 1; lower updates min_lower/max_lower, larger updates min_larger/max_larger; equal touches no extremes.
REQ-016 cls_valid/cls_sel/cls_data SHALL be registered, asserted exactly one cycle after each transfer, 0 otherwise.
REQ-017 out_valid SHALL rise the cycle after the in_last transfer and hold, with all result ports stable, until out_valid&&out_ready.
REQ-018 On that handshake: go IDLE; counts -> 0, min_* -> 8'hFF, max_* -> 8'h00, out_ovf -> 0, in the same edge.
REQ-019 Empty partition SHALL report min 8'hFF, max 8'h00 (init values untouched).
REQ-020 Sum of counts SHALL saturate at BUFF_SIZE; transfers beyond it are not counted, do not update extremes, produce no cls_valid, and set out_ovf sticky for the frame.
REQ-021 Frame of one sample (in_last on first transfer) SHALL be legal: single count = 1, out_valid next cycle.
REQ-022 in_last without in_valid SHALL be ignored.
REQ-023 Count arithmetic SHALL use BUFF_SIZE_BIT width with no wrap (BUFF_SIZE representable).

Reset
REQ-024 aresetn low SHALL asynchronously force IDLE, counts 0, min_* 8'hFF, max_* 8'h00, out_pivot 0, out_median_pos 0, out_ovf 0, out_valid 0, cls_valid 0, cls_sel 0, cls_data 0; in_ready is 1 after deassertion.
REQ-025 Reset mid-frame SHALL discard the partial frame; next transfer after release starts a new frame.

Structure
REQ-026 Class encodings (LOWER/EQUAL/LARGER) and the extreme init constants SHALL live in the shared median package.
REQ-027 One sub-module, partition_classify (combinational compare -> cls_sel), is natural; everything else stays in partition_stats.

Verification
REQ-028 BUFF_SIZE=32, pivot 100, median_pos 16, samples 90,100,110,50,200(last) -> sizes 2/1/2, min_lower 50, max_lower 90, min_larger 110, max_larger 200, out_median_pos 16, out_valid 1 cycle after last.
REQ-029 All 32 samples =7, pivot 7 -> equal_size 32, lower/larger 0, min_* FF, max_* 00, out_ovf 0.
REQ-030 34 samples <pivot, last on 34th -> lower_size 32, out_ovf 1, no cls_valid for samples 33-34.
REQ-031 out_ready held 0 for 5 cycles in OUT with in_valid=1 -> in_ready 0, results stable, no transfer; next frame counts from 0 after release.
REQ-032 in_pivot changed mid-frame 100->10 -> classification still uses 100.
REQ-033 aresetn pulsed low after 3 samples -> all outputs at reset values asynchronously; next 2-sample frame reports only those 2.
